hilo_unit: RTL

- HI/LO register file plus iterative 32x32 multiplier, in the EX stage directly downstream of the instruction decoder.
- Consumes the decoder's HiWrite, LoWrite, Madd, Msub and HiOrLo/HiToReg controls and produces the mfhi/mflo read data.
- Executes mult, multu, madd, msub (multi-cycle) and mthi, mtlo (single-cycle).
- Stalls the pipeline while a multiply is in flight.

---
 rtl/hilo_pkg.sv | 45 ++++
 rtl/hilo_mul_core.sv | 48 ++++
 rtl/hilo_unit.sv | 110 +++++++++++
 3 files changed

// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO unit: FSM states, internal op kinds and default width.
package hilo_pkg;

  localparam int unsigned HILO_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIN
  } state_e;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_MULT,
    OP_MULTU,
    OP_MADD,
    OP_MSUB,
    OP_MTHI,
    OP_MTLO
  } op_e;

  // Decoder controls to op kind; Madd/Msub outrank the HI/LO write enables.
  function automatic op_e hilo_decode(input logic valid,
                                      input logic madd,
                                      input logic msub,
                                      input logic hiwrite,
                                      input logic lowrite,
                                      input logic uns);
    op_e op;
    op = OP_NONE;
    if (valid) begin
      if (madd)                    op = OP_MADD;
      else if (msub)               op = OP_MSUB;
      else if (hiwrite && lowrite) op = uns ? OP_MULTU : OP_MULT;
      else if (hiwrite)            op = OP_MTHI;
      else if (lowrite)            op = OP_MTLO;
    end
    return op;
  endfunction

  function automatic logic is_mul_op(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/hilo_mul_core.sv
// Unsigned iterative shift-add multiplier: one partial product per clock, W iterations.
module hilo_mul_core
  import hilo_pkg::*;
#(
  parameter int unsigned W = HILO_DATA_WIDTH
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   mag_a,
  input  logic [W-1:0]   mag_b,
  output logic [2*W-1:0] prod,
  output logic           done
);

  localparam int unsigned CW = $clog2(W) + 1;

  logic [2*W-1:0] a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           run;

  // High during the edge that performs the final iteration.
  assign done = run && (cnt == CW'(W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      prod <= '0;
      cnt  <= '0;
      run  <= 1'b0;
    end else if (start) begin
      a_sh <= {{W{1'b0}}, mag_a};
      b_sh <= mag_b;
      prod <= '0;
      cnt  <= '0;
      run  <= 1'b1;
    end else if (run) begin
      if (b_sh[0]) prod <= prod + a_sh;
      a_sh <= a_sh << 1;
      b_sh <= b_sh >> 1;
      cnt  <= cnt + 1'b1;
      if (done) run <= 1'b0;
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair with multi-cycle mult/multu/madd/msub and single-cycle mthi/mtlo.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HILO_DATA_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Valid,
  input  logic                  HiWrite,
  input  logic                  LoWrite,
  input  logic                  Madd,
  input  logic                  Msub,
  input  logic                  Unsigned,
  input  logic                  ReadReq,
  input  logic                  HiOrLo,
  input  logic [DATA_WIDTH-1:0] RsData,
  input  logic [DATA_WIDTH-1:0] RtData,
  output logic [DATA_WIDTH-1:0] ReadData,
  output logic                  Busy,
  output logic                  Stall,
  output logic                  Done
);

  localparam int unsigned W = DATA_WIDTH;

  state_e          state;
  op_e             op;
  op_e             op_q;
  logic            neg_q;
  logic [W-1:0]    hi;
  logic [W-1:0]    lo;
  logic            signed_op;
  logic            start;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [2*W-1:0]  prod;
  logic            core_done;
  logic [2*W-1:0]  prod_s;
  logic [2*W-1:0]  result;

  assign op        = hilo_decode(Valid, Madd, Msub, HiWrite, LoWrite, Unsigned);
  assign signed_op = (op != OP_MULTU);
  assign start     = (state == ST_IDLE) && is_mul_op(op);

  // Two's-complement negate also yields the right magnitude for the most negative value.
  always_comb begin
    mag_a = RsData;
    mag_b = RtData;
    if (signed_op && RsData[W-1]) mag_a = -RsData;
    if (signed_op && RtData[W-1]) mag_b = -RtData;
  end

  hilo_mul_core #(.W(W)) u_core (
    .clk   (Clk),
    .reset (Reset),
    .start (start),
    .mag_a (mag_a),
    .mag_b (mag_b),
    .prod  (prod),
    .done  (core_done)
  );

  always_comb begin
    prod_s = neg_q ? -prod : prod;
    case (op_q)
      OP_MADD: result = {hi, lo} + prod_s;
      OP_MSUB: result = {hi, lo} - prod_s;
      default: result = prod_s;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      op_q  <= OP_NONE;
      neg_q <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      Done  <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op == OP_MTHI) hi <= RsData;
          if (op == OP_MTLO) lo <= RsData;
          if (start) begin
            op_q  <= op;
            neg_q <= signed_op && (RsData[W-1] ^ RtData[W-1]);
            state <= ST_MUL;
          end
        end
        ST_MUL: begin
          if (core_done) state <= ST_FIN;
        end
        ST_FIN: begin
          {hi, lo} <= result;
          Done     <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy     = (state != ST_IDLE);
  assign Stall    = Busy && Valid && (HiWrite || LoWrite || Madd || Msub || ReadReq);
  assign ReadData = HiOrLo ? hi : lo;

endmodule
